bow_tx_arbiter: RTL and testbench

Round-robin APB-style arbiter that shares the single BoW transmit link among NUM_REQ requesters. It sits in front of the `Bow_tx` transmitter and drives its `psel_tx`/`penable_tx`/`pwrite_tx`/`pwdata_tx` inputs. It completes each transfer on the `rx_ready` return from the receiver, returns `prdata` to the winner, and aborts any transfer that stalls beyond a programmable timeout.

---
 rtl/bow_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_bow_tx_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bow_tx_arbiter.sv
// Round-robin arbiter sharing one BoW APB transmit link among NUM_REQ requesters; grant->SETUP->ACCESS,
// completion pulse the cycle after rx_ready (or timeout). Losers wait with req_pready low; requests are never dropped.
module bow_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                          txclk,
    input  logic                          presetn,
    input  logic [NUM_REQ-1:0]            req_psel,
    input  logic [NUM_REQ-1:0]            req_penable,
    input  logic [NUM_REQ-1:0]            req_pwrite,
    input  logic [NUM_REQ*DATA_W-1:0]     req_pwdata,
    input  logic                          rx_ready,
    input  logic [DATA_W-1:0]             prdata,
    output logic                          psel_tx,
    output logic                          penable_tx,
    output logic                          pwrite_tx,
    output logic [DATA_W-1:0]             pwdata_tx,
    output logic [NUM_REQ-1:0]            req_pready,
    output logic [NUM_REQ-1:0]            req_perr,
    output logic [DATA_W-1:0]             req_prdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [NUM_REQ-1:0]  pready_q;
    logic [NUM_REQ-1:0]  perr_q;
    logic [DATA_W-1:0]   prdata_q;
    logic [ID_W-1:0]     grant_q;
    logic [ID_W-1:0]     rr_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [NUM_REQ-1:0]  eligible;
    logic                win_vld;
    logic [ID_W-1:0]     win_id;
    logic [DATA_W-1:0]   win_dat;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic [ID_W-1:0]     rr_next;
    logic                timeout_hit;
    logic                unused_penable;

    // The requester being acknowledged still holds psel this cycle; mask it to avoid a double grant.
    assign eligible = req_psel & ~pready_q;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_vld && eligible[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    assign win_dat        = req_pwdata[win_id*DATA_W +: DATA_W];
    assign grant_onehot   = NUM_REQ'(1) << grant_q;
    assign rr_next        = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign timeout_hit    = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign unused_penable = ^req_penable;

    always_ff @(posedge txclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pready_q  <= '0;
            perr_q    <= '0;
            prdata_q  <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            pready_q <= '0;
            perr_q   <= '0;
            prdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        grant_q  <= win_id;
                        pwrite_q <= req_pwrite[win_id];
                        pwdata_q <= win_dat;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // rx_ready takes priority over a coincident timeout.
                    if (rx_ready || timeout_hit) begin
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pready_q  <= grant_onehot;
                        rr_q      <= rr_next;
                        if (rx_ready) begin
                            prdata_q <= prdata;
                        end else begin
                            perr_q   <= grant_onehot;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign psel_tx    = psel_q;
    assign penable_tx = penable_q;
    assign pwrite_tx  = pwrite_q;
    assign pwdata_tx  = pwdata_q;
    assign req_pready = pready_q;
    assign req_perr   = perr_q;
    assign req_prdata = prdata_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bow_tx_arbiter.sv
// Directed bench for bow_tx_arbiter: reset, single write, round-robin, lone repeat, timeout, reset mid-ACCESS.
module tb_bow_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int TO = 8;

    logic               txclk = 1'b0;
    logic               presetn;
    logic [NR-1:0]      req_psel;
    logic [NR-1:0]      req_penable;
    logic [NR-1:0]      req_pwrite;
    logic [NR*DW-1:0]   req_pwdata;
    logic               rx_ready;
    logic [DW-1:0]      prdata;
    logic               psel_tx;
    logic               penable_tx;
    logic               pwrite_tx;
    logic [DW-1:0]      pwdata_tx;
    logic [NR-1:0]      req_pready;
    logic [NR-1:0]      req_perr;
    logic [DW-1:0]      req_prdata;
    logic [1:0]         grant_id;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    bow_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .txclk       (txclk),
        .presetn     (presetn),
        .req_psel    (req_psel),
        .req_penable (req_penable),
        .req_pwrite  (req_pwrite),
        .req_pwdata  (req_pwdata),
        .rx_ready    (rx_ready),
        .prdata      (prdata),
        .psel_tx     (psel_tx),
        .penable_tx  (penable_tx),
        .pwrite_tx   (pwrite_tx),
        .pwdata_tx   (pwdata_tx),
        .req_pready  (req_pready),
        .req_perr    (req_perr),
        .req_prdata  (req_prdata),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 txclk = ~txclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge txclk);
            #1;
        end
    endtask

    initial begin
        presetn     = 1'b0;
        req_psel    = NR'($urandom);
        req_penable = NR'($urandom);
        req_pwrite  = NR'($urandom);
        req_pwdata  = {$urandom, $urandom};
        rx_ready    = 1'b1;
        prdata      = DW'($urandom);
        tick(3);
        check_eq("rst_psel",    psel_tx,    0);
        check_eq("rst_penable", penable_tx, 0);
        check_eq("rst_pwrite",  pwrite_tx,  0);
        check_eq("rst_pwdata",  pwdata_tx,  0);
        check_eq("rst_pready",  req_pready, 0);
        check_eq("rst_perr",    req_perr,   0);
        check_eq("rst_prdata",  req_prdata, 0);
        check_eq("rst_grant",   grant_id,   0);
        check_eq("rst_busy",    busy,       0);

        req_psel    = '0;
        req_penable = '0;
        req_pwrite  = 4'b0010;
        req_pwdata  = {16'h1003, 16'h1002, 16'hA5A5, 16'h1000};
        rx_ready    = 1'b0;
        prdata      = '0;
        presetn     = 1'b1;
        tick(5);
        check_eq("idle_busy", busy,    0);
        check_eq("idle_psel", psel_tx, 0);

        // Single write from requester 1, rx_ready in the 2nd ACCESS cycle.
        req_psel    = 4'b0010;
        req_penable = 4'b0010;
        tick(1);
        check_eq("sw_psel0",    psel_tx,    1);
        check_eq("sw_penable0", penable_tx, 0);
        check_eq("sw_grant",    grant_id,   1);
        check_eq("sw_pwdata",   pwdata_tx,  16'hA5A5);
        check_eq("sw_pwrite",   pwrite_tx,  1);
        check_eq("sw_busy",     busy,       1);
        tick(1);
        check_eq("sw_psel1",    psel_tx,    1);
        check_eq("sw_penable1", penable_tx, 1);
        check_eq("sw_pready1",  req_pready, 0);
        tick(1);
        check_eq("sw_penable2", penable_tx, 1);
        check_eq("sw_pready2",  req_pready, 0);
        rx_ready = 1'b1;
        prdata   = 16'h1234;
        tick(1);
        check_eq("sw_pulse",    req_pready, 4'b0010);
        check_eq("sw_perr",     req_perr,   0);
        check_eq("sw_rdata",    req_prdata, 16'h1234);
        check_eq("sw_psel_end", psel_tx,    0);
        check_eq("sw_pen_end",  penable_tx, 0);
        check_eq("sw_busy_end", busy,       0);
        req_psel    = '0;
        req_penable = '0;
        rx_ready    = 1'b0;
        tick(1);
        check_eq("sw_pulse_one", req_pready, 0);

        // Reset asserted mid-ACCESS on a transfer for requester 3.
        req_psel = 4'b1000;
        tick(1);
        check_eq("rm_grant", grant_id, 3);
        tick(2);
        check_eq("rm_in_access", penable_tx, 1);
        #2;
        presetn = 1'b0;
        #1;
        check_eq("rm_psel",    psel_tx,    0);
        check_eq("rm_penable", penable_tx, 0);
        check_eq("rm_busy",    busy,       0);
        check_eq("rm_grantid", grant_id,   0);
        check_eq("rm_pwdata",  pwdata_tx,  0);
        tick(1);
        check_eq("rm_nopulse", req_pready, 0);
        req_psel   = 4'b1111;
        rx_ready   = 1'b1;
        prdata     = 16'hBEEF;
        req_pwdata = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        presetn    = 1'b1;

        // Round-robin with all requesters and rx_ready tied high; first grant proves rr_ptr cleared.
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % NR;
            tick(1);
            check_eq($sformatf("rr%0d_grant", k),  grant_id,   e);
            check_eq($sformatf("rr%0d_pwdata", k), pwdata_tx,  16'h1000 + e);
            check_eq($sformatf("rr%0d_quiet0", k), req_pready, 0);
            tick(1);
            check_eq($sformatf("rr%0d_penable", k), penable_tx, 1);
            check_eq($sformatf("rr%0d_quiet1", k),  req_pready, 0);
            tick(1);
            check_eq($sformatf("rr%0d_pulse", k), req_pready, 1 << e);
            check_eq($sformatf("rr%0d_rdata", k), req_prdata, 16'hBEEF);
        end
        req_psel = '0;
        tick(1);
        check_eq("rr_idle_busy", busy, 0);

        // Lone requester 2 holding psel: no regrant in its own pulse cycle.
        req_psel = 4'b0100;
        tick(1);
        check_eq("lone_grant1", grant_id, 2);
        tick(2);
        check_eq("lone_pulse1", req_pready, 4'b0100);
        tick(1);
        check_eq("lone_gap_psel",   psel_tx,    0);
        check_eq("lone_gap_busy",   busy,       0);
        check_eq("lone_gap_pready", req_pready, 0);
        tick(1);
        check_eq("lone_psel2",  psel_tx,  1);
        check_eq("lone_grant2", grant_id, 2);
        tick(2);
        check_eq("lone_pulse2", req_pready, 4'b0100);
        req_psel = '0;
        rx_ready = 1'b0;
        tick(1);

        // Timeout on requester 0 (rr_ptr=3), then requester 2 completes on the last allowed cycle.
        req_psel = 4'b0101;
        prdata   = 16'hFFFF;
        tick(1);
        check_eq("to_grant", grant_id, 0);
        tick(1);
        tick(TO - 1);
        check_eq("to_wait_pready", req_pready, 0);
        check_eq("to_wait_psel",   psel_tx,    1);
        tick(1);
        check_eq("to_pready", req_pready, 4'b0001);
        check_eq("to_perr",   req_perr,   4'b0001);
        check_eq("to_rdata",  req_prdata, 0);
        check_eq("to_busy",   busy,       0);
        req_psel = 4'b0100;
        prdata   = 16'h5A5A;
        tick(1);
        check_eq("to_next_grant", grant_id, 2);
        check_eq("to_next_psel",  psel_tx,  1);
        check_eq("to_perr_clr",   req_perr, 0);
        tick(1);
        tick(TO - 1);
        check_eq("tc_wait_pready", req_pready, 0);
        rx_ready = 1'b1;
        tick(1);
        check_eq("tc_pready", req_pready, 4'b0100);
        check_eq("tc_perr",   req_perr,   0);
        check_eq("tc_rdata",  req_prdata, 16'h5A5A);
        rx_ready = 1'b0;
        req_psel = '0;
        tick(2);
        check_eq("end_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
